truth_tbl_preimage_enum: RTL and testbench
==========================================

Name: truth_tbl_preimage_enum

Overview:
Inverse companion to the 4-input Boolean truth-table evaluator family. The evaluator maps {a,b,c,d} to f. This block takes a requested output value f and sequentially streams every 4-bit input combination {a,b,c,d} that produces it, using a val/rdy request/response handshake. It is used by test harnesses and controllers that need the preimage set of a fixed truth table.

Parameters:
TRUTH_TBL, 16'hA533, bit i is f for {a,b,c,d}==i (a is MSB). Default preimages of 1 are 0,1,4,5,8,10,13,15.

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  asynchronous, active-low reset
req_val  input  1  request valid
req_rdy  output  1  request ready; high only in IDLE
req_target  input  1  requested f value; sampled on req_val&&req_rdy
resp_val  output  1  response valid
resp_rdy  input  1  response ready
resp_abcd  output  4  matching input combination {a,b,c,d}
resp_last  output  1  this is the final response of the request
resp_none  output  1  the target has no preimage (table constant)
resp_count  output  5  total number of preimages for the request, 0..16

Behaviour:
- Asynchronous reset (rst_n=0) forces state=IDLE, idx=0, mask=0. Outputs during reset: req_rdy=1, resp_val=0, resp_abcd=0, resp_last=0, resp_none=0, resp_count=0. Reset mid-request abandons the request, and resp_val drops immediately.
- Request accept on an edge with req_val&&req_rdy:
  - latch mask M = req_target ? TRUTH_TBL : ~TRUTH_TBL;
  - latch cnt = popcount(M), 5-bit;
  - idx=0;
  - next state is SEARCH if M!=0, otherwise NONE.
- States:
  - IDLE: req_rdy=1, resp_val=0.
  - SEARCH: resp_val=0, req_rdy=0. Each cycle examines M[idx]. If M[idx]=0 then idx<=idx+1. If M[idx]=1 then go to SEND with idx held. Because M!=0, SEARCH always reaches a set bit and idx never wraps.
  - SEND: resp_val=1, resp_abcd=idx, resp_count=cnt, resp_none=0, and resp_last=1 iff M has no set bit above idx. Outputs are held stable while resp_rdy=0. On resp_rdy: if resp_last, go to IDLE; else idx<=idx+1 and go to SEARCH.
  - NONE: resp_val=1, resp_none=1, resp_last=1, resp_abcd=0, resp_count=0. On resp_rdy, go to IDLE.
- Timing:
  - Latency from the accept edge to the first resp_val is 1 + (index of the first set bit of M) + 1 cycles. Index 0 gives resp_val two cycles after the accept edge.
  - Minimum spacing between consecutive responses is 2 cycles (SEND then SEARCH), plus one cycle per skipped index.
- Request side: req_rdy=0 in every state except IDLE, and requests are ignored there. A new request can be accepted the cycle after the final response handshake, never in the same cycle.
- Outputs are registered state decodes, plus combinational functions of registered M/idx/cnt. There is no input-to-output combinational path other than none.
- idx is 4-bit. It is only incremented when a higher set bit exists, so no wrap-around occurs.

Decomposition:
- Shared package truth_tbl_pkg:
  - state enum {IDLE, SEARCH, SEND, NONE};
  - localparams TBL_N=16, IDX_W=4, CNT_W=5;
  - the default table constant 16'hA533.
- One sub-module, truth_tbl_popcount16: a combinational 16-bit to 5-bit population count, used for cnt.
- The above-idx check (M >> (idx+1)) != 0 stays inline.

Test Plan:
1. Default table, req_target=1, resp_rdy=1 held: expect 8 responses with abcd 0,1,4,5,8,10,13,15. resp_count=8 on each, resp_last only on 15, first resp_val 2 cycles after the accept edge.
2. Default table, req_target=0: expect abcd 2,3,6,7,9,11,12,14 with resp_count=8. req_rdy=0 throughout, and req_rdy=1 the cycle after the handshake on 14.
3. Backpressure: target=1 with resp_rdy low for 5 cycles during the response for abcd=4. resp_val, resp_abcd=4 and resp_last=0 stay stable, then the stream resumes with 5. No index is lost or duplicated.
4. TRUTH_TBL=16'h0000, target=1: a single response with resp_none=1, resp_last=1, resp_count=0, abcd=0. With target=0: 16 responses 0..15, resp_count=16, spacing exactly 2 cycles.
5. Reset mid-stream: assert rst_n=0 while sending abcd=5 for target=1. resp_val falls asynchronously and req_rdy=1. After release, a new target=0 request starts cleanly at abcd=2.
6. Request during busy: pulse req_val with target=0 while SEARCH/SEND is active. The pulse is ignored and the original stream completes unchanged.

Source files
------------

// File: rtl/truth_tbl_pkg.sv
// truth_tbl_pkg: shared types and sizes for the truth-table preimage enumerator.
// Provides the FSM state enum, table/index/count widths and the default table.
package truth_tbl_pkg;
    localparam int TBL_N = 16;
    localparam int IDX_W = 4;
    localparam int CNT_W = 5;
    localparam logic [TBL_N-1:0] TRUTH_TBL_DEFAULT = 16'hA533;
    typedef enum logic [1:0] {IDLE, SEARCH, SEND, NONE} state_e;
endpackage

// File: rtl/truth_tbl_preimage_enum_if.sv
// truth_tbl_preimage_enum_if: request/response handshake bundle.
// master drives req_val/req_target/resp_rdy; slave drives req_rdy and all resp_* outputs.
interface truth_tbl_preimage_enum_if;
    import truth_tbl_pkg::*;
    logic             req_val;
    logic             req_rdy;
    logic             req_target;
    logic             resp_val;
    logic             resp_rdy;
    logic [IDX_W-1:0] resp_abcd;
    logic             resp_last;
    logic             resp_none;
    logic [CNT_W-1:0] resp_count;
    modport master (
        output req_val, req_target, resp_rdy,
        input  req_rdy, resp_val, resp_abcd, resp_last, resp_none, resp_count
    );
    modport slave (
        input  req_val, req_target, resp_rdy,
        output req_rdy, resp_val, resp_abcd, resp_last, resp_none, resp_count
    );
endinterface

// File: rtl/truth_tbl_popcount16.sv
// truth_tbl_popcount16: combinational 16-bit population count.
// i_v: vector to count; o_cnt: number of set bits, 0..16.
module truth_tbl_popcount16
    import truth_tbl_pkg::*;
(
    input  logic [TBL_N-1:0] i_v,
    output logic [CNT_W-1:0] o_cnt
);
    always_comb begin
        o_cnt = '0;
        for (int i = 0; i < TBL_N; i++)
            o_cnt = o_cnt + {{(CNT_W-1){1'b0}}, i_v[i]};
    end
endmodule

// File: rtl/truth_tbl_preimage_enum.sv
// truth_tbl_preimage_enum: streams every {a,b,c,d} whose table entry equals the requested f.
// clk/rst_n: clock and async active-low reset; bus: request (req_*) and response (resp_*) handshake.
module truth_tbl_preimage_enum
    import truth_tbl_pkg::*;
#(
    parameter logic [TBL_N-1:0] TRUTH_TBL = TRUTH_TBL_DEFAULT
)(
    input logic                       clk,
    input logic                       rst_n,
    truth_tbl_preimage_enum_if.slave  bus
);
    state_e           r_state;
    logic [IDX_W-1:0] r_idx;
    logic [TBL_N-1:0] r_mask;
    logic [CNT_W-1:0] r_cnt;
    logic [TBL_N-1:0] w_mask;
    logic [CNT_W-1:0] w_cnt;
    logic             w_accept;
    logic             w_hit;
    logic             w_above;
    assign w_mask   = bus.req_target ? TRUTH_TBL : ~TRUTH_TBL;
    assign w_accept = bus.req_val && r_state == IDLE;
    assign w_hit    = r_mask[r_idx];
    // A 5-bit shift amount lets idx=15 shift everything out instead of wrapping to 0.
    assign w_above  = |(r_mask >> ({1'b0, r_idx} + 5'd1));
    truth_tbl_popcount16 u_pop (
        .i_v   (w_mask),
        .o_cnt (w_cnt)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_mask  <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_accept) begin
                    r_mask  <= w_mask;
                    r_cnt   <= w_cnt;
                    r_idx   <= '0;
                    r_state <= |w_mask ? SEARCH : NONE;
                end
                SEARCH: if (w_hit) r_state <= SEND;
                        else r_idx <= r_idx + IDX_W'(1);
                SEND: if (bus.resp_rdy) begin
                    if (w_above) begin
                        r_idx   <= r_idx + IDX_W'(1);
                        r_state <= SEARCH;
                    end else r_state <= IDLE;
                end
                NONE: if (bus.resp_rdy) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
    assign bus.req_rdy    = r_state == IDLE;
    assign bus.resp_val   = r_state == SEND || r_state == NONE;
    assign bus.resp_abcd  = r_state == SEND ? r_idx : '0;
    assign bus.resp_count = r_state == SEND ? r_cnt : '0;
    assign bus.resp_none  = r_state == NONE;
    assign bus.resp_last  = r_state == NONE || (r_state == SEND && !w_above);
endmodule

// File: tb/tb_truth_tbl_preimage_enum.sv
// tb_truth_tbl_preimage_enum: scoreboard bench for the default table and an all-zero table.
module tb_truth_tbl_preimage_enum;
    typedef struct packed {
        logic [3:0] abcd;
        logic       last;
        logic       none;
        logic [4:0] cnt;
    } exp_t;

    logic clk = 0;
    logic rst_n = 0;
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    exp_t qa[$];
    exp_t qz[$];
    logic z_sp = 0;
    int z_prev = -1;
    int p1[8] = '{0, 1, 4, 5, 8, 10, 13, 15};
    int p0[8] = '{2, 3, 6, 7, 9, 11, 12, 14};

    truth_tbl_preimage_enum_if bus_a();
    truth_tbl_preimage_enum_if bus_z();

    truth_tbl_preimage_enum u_dut (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    truth_tbl_preimage_enum #(.TRUTH_TBL(16'h0000)) u_zero (.clk(clk), .rst_n(rst_n), .bus(bus_z));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus_a.resp_val && bus_a.resp_rdy) begin
            chk("a_req_rdy_busy", 32'(bus_a.req_rdy), 0);
            if (qa.size() == 0) chk("a_unexpected_resp", 32'(bus_a.resp_abcd), 32'hFFFF_FFFF);
            else begin
                e = qa.pop_front();
                chk("a_resp", 32'({bus_a.resp_abcd, bus_a.resp_last, bus_a.resp_none, bus_a.resp_count}), 32'(e));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus_z.resp_val && bus_z.resp_rdy) begin
            if (qz.size() == 0) chk("z_unexpected_resp", 32'(bus_z.resp_abcd), 32'hFFFF_FFFF);
            else begin
                e = qz.pop_front();
                chk("z_resp", 32'({bus_z.resp_abcd, bus_z.resp_last, bus_z.resp_none, bus_z.resp_count}), 32'(e));
            end
            if (z_sp) begin
                if (z_prev >= 0) chk("z_spacing", 32'(cyc - z_prev), 2);
                z_prev = cyc;
            end
        end
    end

    task automatic push_a(input int list[8]);
        for (int i = 0; i < 8; i++) qa.push_back('{4'(list[i]), i == 7, 1'b0, 5'd8});
    endtask

    task automatic req_a(input logic t);
        int n = 0;
        while (!bus_a.req_rdy && n < 100) begin @(posedge clk); #1; n++; end
        if (!bus_a.req_rdy) chk("a_req_rdy_timeout", 0, 1);
        bus_a.req_val = 1;
        bus_a.req_target = t;
        @(posedge clk); #1;
        bus_a.req_val = 0;
    endtask

    task automatic req_z(input logic t);
        bus_z.req_val = 1;
        bus_z.req_target = t;
        @(posedge clk); #1;
        bus_z.req_val = 0;
    endtask

    task automatic drain_a;
        int n = 0;
        while (qa.size() != 0 && n < 400) begin @(posedge clk); n++; end
        if (qa.size() != 0) chk("a_drain_timeout", 32'(qa.size()), 0);
    endtask

    task automatic drain_z;
        int n = 0;
        while (qz.size() != 0 && n < 400) begin @(posedge clk); n++; end
        if (qz.size() != 0) chk("z_drain_timeout", 32'(qz.size()), 0);
    endtask

    task automatic wait_abcd(input logic [3:0] v);
        int n = 0;
        while (!(bus_a.resp_val && bus_a.resp_abcd == v) && n < 100) begin @(posedge clk); #1; n++; end
        chk("a_wait_abcd_seen", 32'(bus_a.resp_val && bus_a.resp_abcd == v), 1);
    endtask

    initial begin
        bus_a.req_val = 0; bus_a.req_target = 0; bus_a.resp_rdy = 1;
        bus_z.req_val = 0; bus_z.req_target = 0; bus_z.resp_rdy = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_rdy", 32'(bus_a.req_rdy), 1);
        chk("rst_resp_val", 32'(bus_a.resp_val), 0);
        chk("rst_outs", 32'({bus_a.resp_abcd, bus_a.resp_last, bus_a.resp_none, bus_a.resp_count}), 0);
        rst_n = 1;
        @(posedge clk); #1;

        // 1: target=1, latency and full stream
        push_a(p1);
        req_a(1);
        chk("t1_resp_val_after_accept", 32'(bus_a.resp_val), 0);
        @(posedge clk); #1;
        chk("t1_resp_val_second_edge", 32'(bus_a.resp_val), 1);
        drain_a();

        // 2: target=0, req_rdy returns the cycle after the last handshake
        @(posedge clk); #1;
        push_a(p0);
        req_a(0);
        drain_a();
        #1;
        chk("t2_req_rdy_after_last", 32'(bus_a.req_rdy), 1);

        // 3: backpressure on abcd=4
        @(posedge clk); #1;
        push_a(p1);
        req_a(1);
        wait_abcd(4);
        bus_a.resp_rdy = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("t3_stall_hold", 32'({bus_a.resp_val, bus_a.resp_abcd, bus_a.resp_last}), 32'({1'b1, 4'd4, 1'b0}));
        end
        bus_a.resp_rdy = 1;
        drain_a();

        // 4: all-zero table
        @(posedge clk); #1;
        qz.push_back('{4'd0, 1'b1, 1'b1, 5'd0});
        req_z(1);
        drain_z();
        @(posedge clk); #1;
        for (int i = 0; i < 16; i++) qz.push_back('{4'(i), i == 15, 1'b0, 5'd16});
        z_sp = 1;
        z_prev = -1;
        req_z(0);
        drain_z();
        @(posedge clk); #1;
        z_sp = 0;
        chk("t4_z_idle", 32'({bus_z.req_rdy, bus_z.resp_val}), 32'(2'b10));

        // 5: reset while abcd=5 is presented
        qa.push_back('{4'd0, 1'b0, 1'b0, 5'd8});
        qa.push_back('{4'd1, 1'b0, 1'b0, 5'd8});
        qa.push_back('{4'd4, 1'b0, 1'b0, 5'd8});
        req_a(1);
        wait_abcd(5);
        rst_n = 0;
        #1;
        chk("t5_async_resp_val", 32'(bus_a.resp_val), 0);
        chk("t5_async_req_rdy", 32'(bus_a.req_rdy), 1);
        chk("t5_queue_consumed", 32'(qa.size()), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        @(posedge clk); #1;
        push_a(p0);
        req_a(0);
        drain_a();

        // 6: request pulse while busy is ignored
        @(posedge clk); #1;
        push_a(p0);
        req_a(0);
        wait_abcd(2);
        bus_a.req_val = 1;
        bus_a.req_target = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("t6_req_rdy_busy", 32'(bus_a.req_rdy), 0);
        end
        bus_a.req_val = 0;
        drain_a();
        repeat (6) @(posedge clk);
        #1;
        chk("t6_idle_after", 32'({bus_a.req_rdy, bus_a.resp_val}), 32'(2'b10));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
